// File: rtl/tcdm_bank_pkg.sv
// Shared types, request field layout and a request pack helper for the TCDM bank adapter.
// The field offsets below describe the default 10-bit address / 32-bit data configuration.
package tcdm_bank_pkg;

    typedef enum logic [1:0] {
        AmoNone = 2'b00,
        AmoAdd  = 2'b01,
        AmoSwap = 2'b10,
        AmoOr   = 2'b11
    } amo_op_e;

    localparam int unsigned AmoWidth        = 2;
    localparam int unsigned DefAddrWidth    = 10;
    localparam int unsigned DefDataWidth    = 32;
    localparam int unsigned DefBeWidth      = DefDataWidth / 8;
    localparam int unsigned DefReqDataWidth = AmoWidth + 1 + DefBeWidth + DefAddrWidth
                                              + DefDataWidth;

    // Packed request layout, MSB to LSB: amo, wen, be, addr, data.
    localparam int unsigned DefDataOff = 0;
    localparam int unsigned DefAddrOff = DefDataOff + DefDataWidth;
    localparam int unsigned DefBeOff   = DefAddrOff + DefAddrWidth;
    localparam int unsigned DefWenOff  = DefBeOff + DefBeWidth;
    localparam int unsigned DefAmoOff  = DefWenOff + 1;

    function automatic logic [DefReqDataWidth-1:0] pack_req(
        input amo_op_e                 amo,
        input logic                    wen,
        input logic [DefBeWidth-1:0]   be,
        input logic [DefAddrWidth-1:0] addr,
        input logic [DefDataWidth-1:0] data
    );
        logic [DefReqDataWidth-1:0] req;
        req = '0;
        req[DefAmoOff +: AmoWidth]     = amo;
        req[DefWenOff]                 = wen;
        req[DefBeOff +: DefBeWidth]    = be;
        req[DefAddrOff +: DefAddrWidth] = addr;
        req[DefDataOff +: DefDataWidth] = data;
        return req;
    endfunction

endpackage

// File: rtl/tcdm_amo_alu.sv
// Combinational new-word generator for the RMW write: byte merge for sub-word stores,
// or the atomic result (ADD/SWAP/OR operate on the full word and ignore the byte enables).
module tcdm_amo_alu
    import tcdm_bank_pkg::*;
#(
    parameter int unsigned  DataWidth = 32,
    localparam int unsigned BeWidth   = DataWidth / 8
) (
    input  logic [DataWidth-1:0] old_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic [BeWidth-1:0]   be_i,
    input  amo_op_e              op_i,
    output logic [DataWidth-1:0] new_o
);

    logic [DataWidth-1:0] merged;

    always_comb begin
        merged = old_i;
        for (int unsigned i = 0; i < BeWidth; i++) begin
            if (be_i[i]) begin
                merged[8*i +: 8] = data_i[8*i +: 8];
            end
        end
    end

    always_comb begin
        new_o = merged;
        unique case (op_i)
            AmoNone: new_o = merged;
            AmoAdd:  new_o = old_i + data_i;
            AmoSwap: new_o = data_i;
            AmoOr:   new_o = old_i | data_i;
        endcase
    end

endmodule

// File: rtl/tcdm_bank_adapter.sv
// Bridges one crossbar output port onto a single-port, word-write-only SRAM bank.
// Sub-word writes (and atomics when TCDM_BANK_ADAPTER_AMO_EN is defined) take a 2-cycle RMW.
module tcdm_bank_adapter
    import tcdm_bank_pkg::*;
#(
    parameter int unsigned  AddrWidth    = 10,
    parameter int unsigned  DataWidth    = 32,
    localparam int unsigned BeWidth      = DataWidth / 8,
    localparam int unsigned ReqDataWidth = 3 + BeWidth + AddrWidth + DataWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ReqDataWidth-1:0] wdata_i,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    bank_req_o,
    output logic                    bank_we_o,
    output logic [AddrWidth-1:0]    bank_addr_o,
    output logic [DataWidth-1:0]    bank_wdata_o,
    input  logic [DataWidth-1:0]    bank_rdata_i,
    output logic                    busy_o
);

    localparam int unsigned DataOff = 0;
    localparam int unsigned AddrOff = DataOff + DataWidth;
    localparam int unsigned BeOff   = AddrOff + AddrWidth;
    localparam int unsigned WenOff  = BeOff + BeWidth;
    localparam int unsigned AmoOff  = WenOff + 1;

    typedef enum logic {StIdle, StRmwWr} state_e;

    state_e               state_q;
    logic [AddrWidth-1:0] rmw_addr_q;
    logic [BeWidth-1:0]   rmw_be_q;
    logic [DataWidth-1:0] rmw_data_q;
    amo_op_e              rmw_op_q;
    logic                 empty_q;

    logic [AmoWidth-1:0]  req_amo_raw;
    amo_op_e              req_amo;
    logic                 req_wen;
    logic [BeWidth-1:0]   req_be;
    logic [AddrWidth-1:0] req_addr;
    logic [DataWidth-1:0] req_data;

    logic                 is_amo;
    logic                 is_full;
    logic                 is_empty;
    logic                 is_rmw;
    logic [DataWidth-1:0] rmw_new;

    assign req_amo_raw = wdata_i[AmoOff +: AmoWidth];
    assign req_wen     = wdata_i[WenOff];
    assign req_be      = wdata_i[BeOff +: BeWidth];
    assign req_addr    = wdata_i[AddrOff +: AddrWidth];
    assign req_data    = wdata_i[DataOff +: DataWidth];

`ifdef TCDM_BANK_ADAPTER_AMO_EN
    assign req_amo = amo_op_e'(req_amo_raw);
`else
    logic unused_amo;
    assign unused_amo = ^req_amo_raw;
    assign req_amo    = AmoNone;
`endif

    // Atomics always go down the RMW path; everything else is classified by wen and be.
    always_comb begin
        is_amo   = (req_amo != AmoNone);
        is_full  = req_wen && (&req_be) && !is_amo;
        is_empty = req_wen && (req_be == '0) && !is_amo;
        is_rmw   = is_amo || (req_wen && !is_full && !is_empty);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            rmw_addr_q <= '0;
            rmw_be_q   <= '0;
            rmw_data_q <= '0;
            rmw_op_q   <= AmoNone;
            empty_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    empty_q <= req_i && is_empty;
                    if (req_i && is_rmw) begin
                        state_q    <= StRmwWr;
                        rmw_addr_q <= req_addr;
                        rmw_be_q   <= req_be;
                        rmw_data_q <= req_data;
                        rmw_op_q   <= req_amo;
                    end
                end
                StRmwWr: begin
                    empty_q <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    tcdm_amo_alu #(
        .DataWidth (DataWidth)
    ) u_amo_alu (
        .old_i  (bank_rdata_i),
        .data_i (rmw_data_q),
        .be_i   (rmw_be_q),
        .op_i   (rmw_op_q),
        .new_o  (rmw_new)
    );

    // The RMW write cycle owns the bank, so any new request is held off for one cycle.
    always_comb begin
        gnt_o        = req_i;
        bank_req_o   = req_i && !is_empty;
        bank_we_o    = req_i && is_full;
        bank_addr_o  = req_addr;
        bank_wdata_o = req_data;
        if (state_q == StRmwWr) begin
            gnt_o        = 1'b0;
            bank_req_o   = 1'b1;
            bank_we_o    = 1'b1;
            bank_addr_o  = rmw_addr_q;
            bank_wdata_o = rmw_new;
        end
    end

    assign busy_o  = (state_q == StRmwWr);
    assign rdata_o = empty_q ? '0 : bank_rdata_i;

endmodule

// File: tb/tb_tcdm_bank_adapter.sv
// Self-checking bench for tcdm_bank_adapter: SRAM model plus a transaction-level memory model.
module tb_tcdm_bank_adapter;
    import tcdm_bank_pkg::*;

    logic        clk;
    logic        rst_ni;
    logic        req;
    logic        gnt_o;
    logic [48:0] wdata;
    logic [31:0] rdata_o;
    logic        bank_req_o;
    logic        bank_we_o;
    logic [9:0]  bank_addr_o;
    logic [31:0] bank_wdata_o;
    logic [31:0] sram_rd;
    logic        busy_o;

    logic [31:0] mem [1024];

    int checks;
    int failures;

    logic [31:0] exp_mem [32];
    logic        exp_busy;
    logic [9:0]  exp_rmw_addr;
    logic [31:0] exp_rmw_val;
    logic        pend_valid;
    logic [31:0] pend_rdata;
    logic [31:0] last_rdata;
    logic        last_gnt;

    tcdm_bank_adapter #(
        .AddrWidth (10),
        .DataWidth (32)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_i        (req),
        .gnt_o        (gnt_o),
        .wdata_i      (wdata),
        .rdata_o      (rdata_o),
        .bank_req_o   (bank_req_o),
        .bank_we_o    (bank_we_o),
        .bank_addr_o  (bank_addr_o),
        .bank_wdata_o (bank_wdata_o),
        .bank_rdata_i (sram_rd),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM with 1-cycle read latency; read data holds across writes.
    always @(posedge clk) begin
        if (bank_req_o) begin
            if (bank_we_o) mem[bank_addr_o] <= bank_wdata_o;
            else           sram_rd <= mem[bank_addr_o];
        end
    end

    function automatic logic [48:0] mk(input logic [1:0] amo, input logic wen,
                                       input logic [3:0] be, input logic [9:0] addr,
                                       input logic [31:0] data);
        return pack_req(amo_op_e'(amo), wen, be, addr, data);
    endfunction

    // One clock cycle: drive, check against the model, then advance the model.
    task automatic cycle(input logic r, input logic [48:0] w);
        logic [1:0]  amo;
        logic        wen;
        logic [3:0]  be;
        logic [9:0]  addr;
        logic [31:0] data;
        logic        exp_gnt;
        logic        is_amo;
        logic [31:0] old_w;
        logic [31:0] new_w;
        {amo, wen, be, addr, data} = w;
        @(negedge clk);
        req   = r;
        wdata = w;
        #1;
        last_rdata = rdata_o;
        if (pend_valid) begin
            checks++;
            if (rdata_o !== pend_rdata) begin
                failures++;
                $display("FAIL rdata: got %h expected %h", rdata_o, pend_rdata);
            end
        end
        pend_valid = 1'b0;
        exp_gnt = r && !exp_busy;
        checks++;
        if (gnt_o !== exp_gnt) begin
            failures++;
            $display("FAIL gnt: got %b expected %b", gnt_o, exp_gnt);
        end
        checks++;
        if (busy_o !== exp_busy) begin
            failures++;
            $display("FAIL busy: got %b expected %b", busy_o, exp_busy);
        end
        if (exp_busy) begin
            checks++;
            if (bank_req_o !== 1'b1 || bank_we_o !== 1'b1 || bank_addr_o !== exp_rmw_addr ||
                bank_wdata_o !== exp_rmw_val) begin
                failures++;
                $display("FAIL rmw_write: got req=%b we=%b addr=%h data=%h expected 1 1 %h %h",
                         bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o,
                         exp_rmw_addr, exp_rmw_val);
            end
            exp_mem[exp_rmw_addr[4:0]] = exp_rmw_val;
        end
        last_gnt = exp_gnt;
        exp_busy = 1'b0;
        if (exp_gnt) begin
            old_w = exp_mem[addr[4:0]];
`ifdef TCDM_BANK_ADAPTER_AMO_EN
            is_amo = (amo != 2'd0);
`else
            is_amo = 1'b0;
`endif
            if (is_amo || (wen && be != 4'hF && be != 4'h0)) begin
                if (is_amo) begin
                    case (amo)
                        2'd1:    new_w = old_w + data;
                        2'd2:    new_w = data;
                        default: new_w = old_w | data;
                    endcase
                end else begin
                    for (int i = 0; i < 4; i++)
                        new_w[8*i +: 8] = be[i] ? data[8*i +: 8] : old_w[8*i +: 8];
                end
                checks++;
                if (bank_req_o !== 1'b1 || bank_we_o !== 1'b0 || bank_addr_o !== addr) begin
                    failures++;
                    $display("FAIL rmw_read: got req=%b we=%b addr=%h expected 1 0 %h",
                             bank_req_o, bank_we_o, bank_addr_o, addr);
                end
                exp_busy     = 1'b1;
                exp_rmw_addr = addr;
                exp_rmw_val  = new_w;
                pend_valid   = 1'b1;
                pend_rdata   = old_w;
            end else if (!wen) begin
                checks++;
                if (bank_req_o !== 1'b1 || bank_we_o !== 1'b0 || bank_addr_o !== addr) begin
                    failures++;
                    $display("FAIL read_access: got req=%b we=%b addr=%h expected 1 0 %h",
                             bank_req_o, bank_we_o, bank_addr_o, addr);
                end
                pend_valid = 1'b1;
                pend_rdata = old_w;
            end else if (be == 4'hF) begin
                checks++;
                if (bank_req_o !== 1'b1 || bank_we_o !== 1'b1 || bank_addr_o !== addr ||
                    bank_wdata_o !== data) begin
                    failures++;
                    $display("FAIL full_write: got req=%b we=%b addr=%h data=%h expected 1 1 %h %h",
                             bank_req_o, bank_we_o, bank_addr_o, bank_wdata_o, addr, data);
                end
                exp_mem[addr[4:0]] = data;
            end else begin
                checks++;
                if (bank_req_o !== 1'b0) begin
                    failures++;
                    $display("FAIL empty_write_req: got %b expected 0", bank_req_o);
                end
                pend_valid = 1'b1;
                pend_rdata = 32'h0;
            end
        end
        @(posedge clk);
    endtask

    // Present a request until the model says it is granted (at most one stall).
    task automatic issue(input logic [48:0] w);
        while (exp_busy) cycle(1'b1, w);
        cycle(1'b1, w);
    endtask

    task automatic idle();
        cycle(1'b0, 49'h0);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req    = 1'b0;
        wdata  = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (gnt_o !== 1'b0 || busy_o !== 1'b0 || rdata_o !== sram_rd) begin
            failures++;
            $display("FAIL reset_idle: got gnt=%b busy=%b rdata=%h expected 0 0 %h",
                     gnt_o, busy_o, rdata_o, sram_rd);
        end
        req   = 1'b1;
        wdata = mk(2'd0, 1'b0, 4'hF, 10'h0, 32'h0);
        #1;
        checks++;
        if (gnt_o !== 1'b1 || bank_req_o !== 1'b1 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_req: got gnt=%b bank_req=%b busy=%b expected 1 1 0",
                     gnt_o, bank_req_o, busy_o);
        end
        req = 1'b0;
        @(negedge clk);
        rst_ni     = 1'b1;
        exp_busy   = 1'b0;
        pend_valid = 1'b0;
    endtask

    task automatic test_init();
        for (int a = 0; a < 32; a++) issue(mk(2'd0, 1'b1, 4'hF, 10'(a), $urandom));
    endtask

    task automatic test_full_write();
        issue(mk(2'd0, 1'b1, 4'hF, 10'h010, 32'hDEADBEEF));
        issue(mk(2'd0, 1'b0, 4'hF, 10'h010, 32'h0));
        idle();
        check_val("full_write_readback", last_rdata, 32'hDEADBEEF);
    endtask

    task automatic test_partial_write();
        issue(mk(2'd0, 1'b1, 4'hF, 10'h005, 32'h11223344));
        issue(mk(2'd0, 1'b1, 4'b0010, 10'h005, 32'h0000AA00));
        idle();
        check_val("partial_old_rdata", last_rdata, 32'h11223344);
        issue(mk(2'd0, 1'b0, 4'hF, 10'h005, 32'h0));
        idle();
        check_val("partial_merged", last_rdata, 32'h1122AA44);
    endtask

    task automatic test_back_to_back();
        issue(mk(2'd0, 1'b1, 4'hF, 10'h007, 32'hA0B0C0D0));
        issue(mk(2'd0, 1'b1, 4'b1001, 10'h007, 32'h11000022));
        issue(mk(2'd0, 1'b0, 4'hF, 10'h007, 32'h0));
        idle();
        check_val("b2b_read", last_rdata, 32'h11B0C022);
    endtask

    task automatic test_empty_write();
        issue(mk(2'd0, 1'b1, 4'hF, 10'h009, 32'hCAFEF00D));
        issue(mk(2'd0, 1'b1, 4'h0, 10'h009, 32'h12345678));
        issue(mk(2'd0, 1'b0, 4'hF, 10'h009, 32'h0));
        idle();
        check_val("empty_write_unchanged", last_rdata, 32'hCAFEF00D);
    endtask

    task automatic test_reset_mid_rmw();
        issue(mk(2'd0, 1'b1, 4'hF, 10'h00C, 32'h55AA55AA));
        issue(mk(2'd0, 1'b1, 4'b0001, 10'h00C, 32'h000000FF));
        @(negedge clk);
        req = 1'b0;
        #1;
        check_val("mid_rmw_busy", 32'(busy_o), 32'h1);
        rst_ni = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || bank_we_o !== 1'b0 || bank_req_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_rmw_reset: got busy=%b we=%b req=%b expected 0 0 0",
                     busy_o, bank_we_o, bank_req_o);
        end
        @(negedge clk);
        rst_ni     = 1'b1;
        exp_busy   = 1'b0;
        pend_valid = 1'b0;
        issue(mk(2'd0, 1'b0, 4'hF, 10'h00C, 32'h0));
        idle();
        check_val("mid_rmw_old_kept", last_rdata, 32'h55AA55AA);
    endtask

    task automatic test_amo();
        issue(mk(2'd0, 1'b1, 4'hF, 10'h003, 32'hFFFFFFFE));
        issue(mk(2'd1, 1'b1, 4'hF, 10'h003, 32'h00000005));
        idle();
`ifdef TCDM_BANK_ADAPTER_AMO_EN
        check_val("amo_old_rdata", last_rdata, 32'hFFFFFFFE);
`endif
        issue(mk(2'd0, 1'b0, 4'hF, 10'h003, 32'h0));
        idle();
`ifdef TCDM_BANK_ADAPTER_AMO_EN
        check_val("amo_add_result", last_rdata, 32'h00000003);
`else
        check_val("amo_as_full_write", last_rdata, 32'h00000005);
`endif
    endtask

    task automatic test_random();
        logic [1:0] amo;
        logic [3:0] be;
        int         sel;
        for (int n = 0; n < 300; n++) begin
            amo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            sel = $urandom_range(0, 3);
            be  = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom);
            if ($urandom_range(0, 3) != 0)
                issue(mk(amo, 1'($urandom), be, 10'($urandom_range(0, 31)), $urandom));
            else
                cycle(1'b0, mk(amo, 1'($urandom), be, 10'($urandom_range(0, 31)), $urandom));
        end
        idle();
        idle();
    endtask

    task automatic test_final_mem();
        for (int a = 0; a < 32; a++) check_val("sram_content", mem[a], exp_mem[a]);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        exp_busy   = 1'b0;
        pend_valid = 1'b0;
        last_gnt   = 1'b0;
        test_reset();
        test_init();
        test_full_write();
        test_partial_write();
        test_back_to_back();
        test_empty_write();
        test_reset_mid_rmw();
        test_amo();
        test_random();
        test_final_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
